// File: rtl/serial_compare.sv
// serial_compare
//
// Multi-cycle magnitude/equality comparator. On an accepted start the two
// WIDTH-bit operands and the compare mode are latched. The operands are then
// walked MSB-first, STEP bits per clock, building the XOR mask, the index of
// the most significant differing bit, and the lt/gt decision taken at that
// bit. All chunks are always processed, so the latency is fixed at
// WIDTH/STEP + 1 edges from start to done.
//
// Parameters
//   WIDTH        operand width in bits (>= 2)
//   STEP         bits examined per clock; must divide WIDTH exactly
//   FDW          width of first_diff, max(1, clog2(WIDTH)); derived
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        compare request, sampled on the rising edge (IDLE/DONE only)
//   signed_mode  1 = two's-complement compare, 0 = unsigned; latched with start
//   a, b         operands; latched with start
//   busy         compare in progress
//   done         one-cycle pulse, results valid
//   eq, lt, gt   comparison result; exactly one is set after done
//   diff_mask    a XOR b
//   first_diff   index of the most significant set bit of diff_mask, 0 if eq
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results from the last compare held
// RUN   | one chunk processed per cycle, chunk counter counts down
// DONE  | results valid, done pulsed; start here begins a new compare

module serial_compare #(
  parameter int WIDTH = 6,
  parameter int STEP  = 1,
  localparam int FDW  = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [WIDTH-1:0] diff_mask,
  output logic [FDW-1:0]   first_diff
);

  localparam int N  = (STEP > 0) ? WIDTH / STEP : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_compare: WIDTH must be at least 2");
  end
  if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("serial_compare: STEP must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic             found;
  logic             accept;
  logic             last;

  // per-chunk evaluation
  int               base;
  int               abs_idx;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] a_sh;
  logic [STEP-1:0]  chunk_x;
  logic             hit;
  int               hi_j;
  logic             a_bit;
  logic             top_bit;
  logic             chunk_gt;
  logic [WIDTH-1:0] mask_next;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    last       = (cnt == '0);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Chunk evaluation: the counter selects bits [cnt*STEP +: STEP], so the
  // first RUN cycle (cnt = N-1) covers the MSB chunk.
  // ---------------------------------------------------------------------
  always_comb begin
    base    = int'(cnt) * STEP;
    x_sh    = (a_q ^ b_q) >> base;
    chunk_x = x_sh[STEP-1:0];
    hit     = |chunk_x;
    hi_j    = 0;
    for (int j = 0; j < STEP; j++) begin
      if (chunk_x[j]) begin
        hi_j = j;
      end
    end
    abs_idx = base + hi_j;
    a_sh    = a_q >> abs_idx;
    a_bit   = a_sh[0];
    // Signed compare is an unsigned compare with both sign bits inverted,
    // which only flips the decision when the first difference is the MSB.
    top_bit   = (abs_idx == WIDTH - 1);
    chunk_gt  = a_bit ^ (mode_q & top_bit);
    mask_next = diff_mask | (WIDTH'(chunk_x) << base);
  end

  // ---------------------------------------------------------------------
  // Datapath / result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      found      <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      gt         <= 1'b0;
      diff_mask  <= '0;
      first_diff <= '0;
    end else if (accept) begin
      a_q        <= a;
      b_q        <= b;
      mode_q     <= signed_mode;
      cnt        <= CW'(N - 1);
      found      <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      gt         <= 1'b0;
      diff_mask  <= '0;
      first_diff <= '0;
    end else if (state == RUN) begin
      diff_mask <= mask_next;
      if (!last) begin
        cnt <= cnt - CW'(1);
      end
      if (!found && hit) begin
        found      <= 1'b1;
        first_diff <= FDW'(abs_idx);
        gt         <= chunk_gt;
        lt         <= ~chunk_gt;
      end
      if (last) begin
        eq <= ~(found | hit);
      end
    end
  end

endmodule

// File: tb/tb_serial_compare.sv
// Testbench for serial_compare: four instances (STEP = 1, 2, 3, 6) share the
// stimulus; expected results come from a behavioural model and are queued at
// start, then popped when done is observed.

module tb_serial_compare;

  localparam int W  = 6;
  localparam int ND = 4;
  localparam int STEPS [ND] = '{1, 2, 3, 6};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  a, b;
  logic [ND-1:0] busy_v, done_v, eq_v, lt_v, gt_v;
  logic [W-1:0]  mask_v [ND];
  logic [2:0]    fd_v [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    serial_compare #(.WIDTH(W), .STEP(STEPS[g])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_mode(signed_mode),
      .a          (a),
      .b          (b),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .eq         (eq_v[g]),
      .lt         (lt_v[g]),
      .gt         (gt_v[g]),
      .diff_mask  (mask_v[g]),
      .first_diff (fd_v[g])
    );
  end

  typedef struct packed {
    logic         eq;
    logic         lt;
    logic         gt;
    logic [W-1:0] mask;
    logic [2:0]   fd;
  } res_t;

  res_t sb [$];
  res_t last_exp;
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic m);
    res_t r;
    r      = '0;
    r.mask = x ^ y;
    for (int i = 0; i < W; i++) begin
      if (r.mask[i]) r.fd = 3'(i);
    end
    if (x == y) r.eq = 1'b1;
    else if (m ? ($signed(x) < $signed(y)) : (x < y)) r.lt = 1'b1;
    else r.gt = 1'b1;
    return r;
  endfunction

  function automatic res_t got(input int d);
    return {eq_v[d], lt_v[d], gt_v[d], mask_v[d], fd_v[d]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one compare on all instances and checks latency, busy length,
  // single done pulse and results. With intr set, start is held one more
  // cycle with different operands while every instance is busy.
  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic m, input bit intr);
    int   lat  [ND];
    int   bcnt [ND];
    int   dcnt [ND];
    res_t cap  [ND];
    res_t e;
    for (int d = 0; d < ND; d++) begin
      lat[d] = 0; bcnt[d] = 0; dcnt[d] = 0; cap[d] = '0;
    end
    @(negedge clk);
    a = x; b = y; signed_mode = m; start = 1'b1;
    sb.push_back(model(x, y, m));
    @(posedge clk);
    @(negedge clk);
    if (intr) begin
      a = ~x; b = x; signed_mode = ~m;
    end else begin
      start = 1'b0;
    end
    for (int t = 1; t <= 12; t++) begin
      if (t > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (t == 2) begin
        start = 1'b0; a = y; b = ~y;
      end
      for (int d = 0; d < ND; d++) begin
        bcnt[d] += int'(busy_v[d]);
        if (done_v[d]) begin
          dcnt[d]++;
          if (lat[d] == 0) begin
            lat[d] = t;
            cap[d] = got(d);
          end
        end
      end
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("latency_s%0d", STEPS[d]), 16'(lat[d]), 16'(W / STEPS[d] + 1));
      chk($sformatf("busy_len_s%0d", STEPS[d]), 16'(bcnt[d]), 16'(W / STEPS[d]));
      chk($sformatf("done_pulses_s%0d", STEPS[d]), 16'(dcnt[d]), 16'd1);
      chk($sformatf("result_s%0d", STEPS[d]), 16'(cap[d]), 16'(e));
    end
    last_exp = e;
  endtask

  task automatic wait_done0(output int t);
    @(posedge clk);
    @(negedge clk);
    t = 1;
    while (!done_v[0] && t < 12) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    int   t;
    int   dn;
    res_t e;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_s%0d", STEPS[d]),
          16'({busy_v[d], done_v[d], got(d)}), 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 16'({busy_v[0], done_v[0], got(0)}), 16'd0);

    // unsigned basic vector, all STEP variants
    run_cmp(6'b001010, 6'b000100, 1'b0, 1'b0);
    chk("t1_expected_const", 16'(last_exp), 16'({1'b0, 1'b0, 1'b1, 6'b001110, 3'd3}));

    // results hold after done while inputs wiggle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    end
    chk("hold_result", 16'(got(0)), 16'(last_exp));
    chk("hold_no_done", 16'({busy_v[0], done_v[0]}), 16'd0);

    // equality
    run_cmp(6'b000001, 6'b000001, 1'b0, 1'b0);
    run_cmp(6'b100000, 6'b100000, 1'b0, 1'b0);

    // signed vs unsigned on MSB difference
    run_cmp(6'b100000, 6'b000001, 1'b1, 1'b0);
    chk("signed_lt_const", 16'(last_exp), 16'({1'b0, 1'b1, 1'b0, 6'b100001, 3'd5}));
    run_cmp(6'b100000, 6'b000001, 1'b0, 1'b0);

    // start while busy is ignored
    run_cmp(6'b001010, 6'b000100, 1'b0, 1'b1);
    run_cmp(6'b110011, 6'b110101, 1'b1, 1'b1);

    // a few random vectors in both modes
    for (int i = 0; i < 4; i++) begin
      run_cmp(W'($urandom), W'($urandom), 1'(i), 1'b0);
    end

    // back-to-back: start held high through done
    @(negedge clk);
    a = 6'b001010; b = 6'b000100; signed_mode = 1'b0; start = 1'b1;
    sb.push_back(model(a, b, signed_mode));
    wait_done0(t);
    chk("b2b_latency1", 16'(t), 16'd7);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("b2b_result1", 16'(got(0)), 16'(e));
    a = 6'b100000; b = 6'b000001; signed_mode = 1'b1;
    sb.push_back(model(a, b, signed_mode));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart_busy", 16'({busy_v[0], done_v[0]}), 16'b10);
    chk("b2b_cleared", 16'(got(0)), 16'd0);
    t = 1;
    while (!done_v[0] && t < 12) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    chk("b2b_latency2", 16'(t), 16'd7);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("b2b_result2", 16'(got(0)), 16'(e));
    repeat (3) @(negedge clk);

    // asynchronous reset 3 cycles into a compare
    @(negedge clk);
    a = 6'b001010; b = 6'b000100; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_zero_s1", 16'({busy_v[0], done_v[0], got(0)}), 16'd0);
    chk("abort_zero_s2", 16'({busy_v[1], done_v[1], got(1)}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dn += int'(done_v[0]) + int'(done_v[1]);
    end
    chk("abort_no_done", 16'(dn), 16'd0);

    // fresh compare after reset
    run_cmp(6'b001010, 6'b000100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
